// File: rtl/serdes_tx_serializer.sv
// serdes_tx_serializer: AXIS byte -> 8b/10b symbol -> serial bit stream.
// Frames are one K28.5 comma plus NUM_BYTES_PER_PACKET-1 data symbols.
// Ports:
//   clk, rst            bit clock, sync active-high reset
//   s_axis_tdata/tvalid byte input; s_axis_tready accepts at a boundary
//   strobout            serial line bit, symbol bit a first
//   sym_start           high while strobout carries bit a
//   comma_out           high while strobout carries a K28.5 bit
module serdes_tx_serializer #(
  parameter int NUM_BYTES_PER_PACKET = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       strobout,
  output logic       sym_start,
  output logic       comma_out
);

  localparam int SW = $clog2(NUM_BYTES_PER_PACKET);
  localparam logic [SW-1:0] LAST = SW'(NUM_BYTES_PER_PACKET - 1);
  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;

  // 5b/6b codes, abcdei, RD- column
  function automatic logic [5:0] enc6(input logic [4:0] x);
    case (x)
      5'd0:  enc6 = 6'b100111;
      5'd1:  enc6 = 6'b011101;
      5'd2:  enc6 = 6'b101101;
      5'd3:  enc6 = 6'b110001;
      5'd4:  enc6 = 6'b110101;
      5'd5:  enc6 = 6'b101001;
      5'd6:  enc6 = 6'b011001;
      5'd7:  enc6 = 6'b111000;
      5'd8:  enc6 = 6'b111001;
      5'd9:  enc6 = 6'b100101;
      5'd10: enc6 = 6'b010101;
      5'd11: enc6 = 6'b110100;
      5'd12: enc6 = 6'b001101;
      5'd13: enc6 = 6'b101100;
      5'd14: enc6 = 6'b011100;
      5'd15: enc6 = 6'b010111;
      5'd16: enc6 = 6'b011011;
      5'd17: enc6 = 6'b100011;
      5'd18: enc6 = 6'b010011;
      5'd19: enc6 = 6'b110010;
      5'd20: enc6 = 6'b001011;
      5'd21: enc6 = 6'b101010;
      5'd22: enc6 = 6'b011010;
      5'd23: enc6 = 6'b111010;
      5'd24: enc6 = 6'b110011;
      5'd25: enc6 = 6'b100110;
      5'd26: enc6 = 6'b010110;
      5'd27: enc6 = 6'b110110;
      5'd28: enc6 = 6'b001110;
      5'd29: enc6 = 6'b101110;
      5'd30: enc6 = 6'b011110;
      default: enc6 = 6'b101011;
    endcase
  endfunction

  // 3b/4b codes, fghj, RD- column (primary D.x.7)
  function automatic logic [3:0] enc4(input logic [2:0] y);
    case (y)
      3'd0:  enc4 = 4'b1011;
      3'd1:  enc4 = 4'b1001;
      3'd2:  enc4 = 4'b0101;
      3'd3:  enc4 = 4'b1100;
      3'd4:  enc4 = 4'b1101;
      3'd5:  enc4 = 4'b1010;
      3'd6:  enc4 = 4'b0110;
      default: enc4 = 4'b1110;
    endcase
  endfunction

  function automatic logic [2:0] ones6(input logic [5:0] c);
    ones6 = 3'(c[0]) + 3'(c[1]) + 3'(c[2])
          + 3'(c[3]) + 3'(c[4]) + 3'(c[5]);
  endfunction

  function automatic logic [2:0] ones4(input logic [3:0] c);
    ones4 = 3'(c[0]) + 3'(c[1]) + 3'(c[2]) + 3'(c[3]);
  endfunction

  logic [9:0]    sym_q, sym_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          rd_q, rd_d;
  logic          is_k_q, is_k_d;

  // rd: 1 = RD+, 0 = RD-
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] c6_neg, c6;
  logic [3:0] c4_neg, c4;
  logic       bal6, bal4, rd_mid, alt7;
  logic [9:0] d_sym;
  logic       d_rd;

  always_comb begin
    x      = s_axis_tdata[4:0];
    y      = s_axis_tdata[7:5];
    c6_neg = enc6(x);
    bal6   = (ones6(c6_neg) == 3'd3);
    // D.7 is balanced but still has two spellings
    c6     = (rd_q && (!bal6 || x == 5'd7)) ? ~c6_neg : c6_neg;
    rd_mid = bal6 ? rd_q : ~rd_q;
    // A7 avoids a run of five equal bits across the sub-blocks
    alt7   = (y == 3'd7) &&
             (rd_mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                     : (x == 5'd17 || x == 5'd18 || x == 5'd20));
    c4_neg = alt7 ? 4'b0111 : enc4(y);
    bal4   = (ones4(c4_neg) == 3'd2);
    c4     = (rd_mid && (!bal4 || y == 3'd3)) ? ~c4_neg : c4_neg;
    d_sym  = {c6, c4};
    d_rd   = bal4 ? rd_mid : ~rd_mid;
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q + 4'd1;
    sym_d         = sym_q;
    rd_d          = rd_q;
    slot_d        = slot_q;
    is_k_d        = is_k_q;
    s_axis_tready = 1'b0;
    if (bit_cnt_q == 4'd9) begin
      bit_cnt_d = 4'd0;
      if (slot_q == '0 || !s_axis_tvalid) begin
        // forced or idle comma; always flips rd
        sym_d  = rd_q ? K285_P : K285_N;
        rd_d   = ~rd_q;
        slot_d = SW'(1);
        is_k_d = 1'b1;
      end else begin
        // rst gate keeps a byte from being taken then discarded
        s_axis_tready = ~rst;
        sym_d         = d_sym;
        rd_d          = d_rd;
        is_k_d        = 1'b0;
        slot_d        = (slot_q == LAST) ? '0 : slot_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q     <= K285_N;
      rd_q      <= 1'b1;
      bit_cnt_q <= 4'd0;
      slot_q    <= SW'(1);
      is_k_q    <= 1'b1;
      strobout  <= 1'b0;
      sym_start <= 1'b0;
      comma_out <= 1'b0;
    end else begin
      sym_q     <= sym_d;
      rd_q      <= rd_d;
      bit_cnt_q <= bit_cnt_d;
      slot_q    <= slot_d;
      is_k_q    <= is_k_d;
      strobout  <= sym_q[4'd9 - bit_cnt_q];
      sym_start <= (bit_cnt_q == 4'd0);
      comma_out <= is_k_q;
    end
  end

endmodule

// File: tb/tb_serdes_tx_serializer.sv
// tb_serdes_tx_serializer: directed stimulus, queued expected symbols,
// monitor reassembles strobout into symbols and compares.
module tb_serdes_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       strobout;
  logic       sym_start;
  logic       comma_out;

  always #5 clk = ~clk;

  serdes_tx_serializer #(.NUM_BYTES_PER_PACKET(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .strobout     (strobout),
    .sym_start    (sym_start),
    .comma_out    (comma_out)
  );

  localparam logic [9:0] KN    = 10'b0011111010;
  localparam logic [9:0] KP    = 10'b1100000101;
  localparam logic [9:0] D00P  = 10'b0110001011;
  localparam logic [9:0] D00N  = 10'b1001110100;
  localparam logic [9:0] D285  = 10'b0011101010;
  localparam logic [9:0] D237P = 10'b0001011110;
  localparam logic [9:0] D237N = 10'b1110100001;
  localparam logic [9:0] D177P = 10'b1000110001;
  localparam logic [9:0] D177N = 10'b1000110111;
  localparam logic [9:0] D117P = 10'b1101001000;
  localparam logic [9:0] D117N = 10'b1101001110;
  localparam logic [9:0] D33P  = 10'b1100010011;
  localparam logic [9:0] D33N  = 10'b1100011100;
  localparam logic [9:0] D70P  = 10'b0001110100;
  localparam logic [9:0] D70N  = 10'b1110001011;

  typedef struct {
    logic [9:0] s;
    logic       k;
  } exp_t;

  exp_t exp_q[$];
  int   hs_q[$];
  int   exp_hs[$];
  exp_t me;
  int   cyc   = -1;
  int   bpos  = -1;
  int   rdacc = -1;
  int   ones;
  logic [9:0] acc = '0;
  int   ncmp = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [9:0] s, input logic k);
    exp_t e;
    e.s = s;
    e.k = k;
    exp_q.push_back(e);
  endtask

  // monitor: samples 1 time unit after each falling edge
  always @(negedge clk) begin
    #1;
    if (rst) begin
      cyc   = -1;
      bpos  = -1;
      rdacc = -1;
    end else begin
      cyc++;
      if (s_axis_tready && s_axis_tvalid) hs_q.push_back(cyc);
      if (bpos < 0 && sym_start) bpos = 0;
      if (bpos >= 0) begin
        chk("sym_start", int'(sym_start), int'(bpos == 0));
        if (exp_q.size() > 0)
          chk("comma_out", int'(comma_out), int'(exp_q[0].k));
        acc = {acc[8:0], strobout};
        bpos++;
        if (bpos == 10) begin
          bpos  = 0;
          ones  = $countones(acc);
          rdacc = rdacc + 2 * ones - 10;
          chk("ones_4_to_6", int'(ones >= 4 && ones <= 6), 1);
          chk("rd_bound", int'(rdacc == 1 || rdacc == -1), 1);
          if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("symbol", int'(acc), int'(me.s));
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    hs_q.delete();
    exp_hs.delete();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (s_axis_tready) ok = 1'b1;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    chk("send_accept", int'(ok), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++)
      @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_hs(input string nm);
    chk({nm, "_count"}, hs_q.size(), exp_hs.size());
    for (int i = 0; i < exp_hs.size() && i < hs_q.size(); i++)
      chk(nm, hs_q[i], exp_hs[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // idle stream
    do_reset();
    push(KN, 1'b1); push(KP, 1'b1);
    push(KN, 1'b1); push(KP, 1'b1);
    #1;
    chk("rst_strobout", int'(strobout), 0);
    chk("rst_sym_start", int'(sym_start), 0);
    chk("rst_comma_out", int'(comma_out), 0);
    chk("rst_tready", int'(s_axis_tready), 0);
    @(negedge clk);
    #1;
    chk("e1_strobout", int'(strobout), 0);
    chk("e1_sym_start", int'(sym_start), 1);
    chk("e1_comma_out", int'(comma_out), 1);
    drain();
    chk_hs("idle_hs");

    // first byte after reset
    do_reset();
    push(KN, 1'b1); push(D00P, 1'b0); push(KP, 1'b1);
    send(8'h00);
    drain();
    exp_hs.push_back(9);
    chk_hs("first_hs");

    // full frame of zeros
    do_reset();
    push(KN, 1'b1);
    for (int i = 0; i < 7; i++) push(D00P, 1'b0);
    push(KP, 1'b1); push(D00N, 1'b0); push(KN, 1'b1);
    for (int i = 0; i < 8; i++) send(8'h00);
    drain();
    for (int i = 0; i < 7; i++) exp_hs.push_back(9 + 10 * i);
    exp_hs.push_back(89);
    chk_hs("frame_hs");

    // gap mid-frame
    do_reset();
    push(KN, 1'b1); push(D00P, 1'b0); push(D00P, 1'b0);
    push(KP, 1'b1);
    for (int i = 0; i < 7; i++) push(D285, 1'b0);
    push(KN, 1'b1); push(D237P, 1'b0); push(KP, 1'b1);
    send(8'h00);
    send(8'h00);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 7; i++) send(8'hBC);
    send(8'hF7);
    drain();
    exp_hs.push_back(9); exp_hs.push_back(19);
    for (int i = 0; i < 7; i++) exp_hs.push_back(39 + 10 * i);
    exp_hs.push_back(119);
    chk_hs("gap_hs");

    // reset during bit 4 of a data symbol
    do_reset();
    push(KN, 1'b1);
    send(8'h00);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_strobout", int'(strobout), 0);
    chk("mid_sym_start", int'(sym_start), 0);
    chk("mid_comma_out", int'(comma_out), 0);
    chk("mid_tready", int'(s_axis_tready), 0);
    chk("mid_pending", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    hs_q.delete();
    push(KN, 1'b1); push(KP, 1'b1);
    drain();
    chk_hs("mid_hs");

    // disparity mix incl. A7 and D.x.3
    do_reset();
    push(KN, 1'b1);
    push(D237P, 1'b0); push(D285, 1'b0); push(D177P, 1'b0);
    push(D117N, 1'b0); push(D33P, 1'b0); push(D70P, 1'b0);
    push(D237N, 1'b0);
    push(KN, 1'b1);
    push(D117P, 1'b0); push(D177N, 1'b0); push(D70P, 1'b0);
    push(D33N, 1'b0); push(D237N, 1'b0); push(D285, 1'b0);
    push(D70N, 1'b0);
    push(KP, 1'b1);
    send(8'hF7); send(8'hBC); send(8'hF1); send(8'hEB);
    send(8'h63); send(8'h07); send(8'hF7);
    send(8'hEB); send(8'hF1); send(8'h07); send(8'h63);
    send(8'hF7); send(8'hBC); send(8'h07);
    drain();
    chk("disp_hs_count", hs_q.size(), 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
